// File: rtl/pmod_pkg.sv
// Shared constants and helpers for the PMOD input conditioner.
// Mode encodings select which per-channel source drives pin_out.
package pmod_pkg;

    localparam logic [1:0] MODE_RAW    = 2'b00;
    localparam logic [1:0] MODE_LEVEL  = 2'b01;
    localparam logic [1:0] MODE_TOGGLE = 2'b10;
    localparam logic [1:0] MODE_PULSE  = 2'b11;

    // One spare bit above clog2 so the terminal count always fits, even for 1.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/pmod_chan_debounce.sv
// One PMOD channel: synchroniser chain, debounce counter, stable level,
// toggle state and debounced edge strobes.
module pmod_chan_debounce
    import pmod_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit IDLE_LEVEL      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    output logic sample,
    output logic stable,
    output logic toggle,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   stable_r;
    logic                   toggle_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   sample_s;

    assign sample_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain moving the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pin_in};
        end
    end

    // Debounce counter, accepted level, toggle state and edge strobes.
    // Strobes are registered so they appear with the new stable level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= CNT_ZERO;
            stable_r <= IDLE_LEVEL;
            toggle_r <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else if (sample_s == stable_r) begin
            cnt_r  <= CNT_ZERO;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r    <= CNT_ZERO;
            stable_r <= sample_s;
            toggle_r <= toggle_r ^ sample_s;
            rise_r   <= sample_s;
            fall_r   <= ~sample_s;
        end else begin
            cnt_r  <= cnt_r + CNT_ONE;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end
    end

    assign sample = sample_s;
    assign stable = stable_r;
    assign toggle = toggle_r;
    assign rise   = rise_r;
    assign fall   = fall_r;

endmodule

// File: rtl/pmod_input_conditioner.sv
// Conditions CHANNELS asynchronous PMOD pins and drives a registered,
// mode-selected output per channel plus debounced edge strobes.
module pmod_input_conditioner
    import pmod_pkg::*;
#(
    parameter int CHANNELS        = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit IDLE_LEVEL      = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] pin_in,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] pin_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);

    logic [CHANNELS-1:0] sample_s;
    logic [CHANNELS-1:0] stable_s;
    logic [CHANNELS-1:0] toggle_s;
    logic [CHANNELS-1:0] rise_s;
    logic [CHANNELS-1:0] fall_s;
    logic [CHANNELS-1:0] pin_next_s;
    logic [CHANNELS-1:0] pin_out_r;
    logic                any_change_r;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pmod_chan_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE_LEVEL     (IDLE_LEVEL)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .pin_in(pin_in[i]),
            .sample(sample_s[i]),
            .stable(stable_s[i]),
            .toggle(toggle_s[i]),
            .rise  (rise_s[i]),
            .fall  (fall_s[i])
        );
    end

    // Output source select; PULSE forwards the rise strobe one cycle late.
    always_comb begin
        pin_next_s = {CHANNELS{IDLE_LEVEL}};
        case (mode)
            MODE_RAW:    pin_next_s = sample_s;
            MODE_LEVEL:  pin_next_s = stable_s;
            MODE_TOGGLE: pin_next_s = toggle_s;
            MODE_PULSE:  pin_next_s = rise_s;
            default:     pin_next_s = {CHANNELS{IDLE_LEVEL}};
        endcase
    end

    // Registered pin_out and the delayed any-edge summary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_out_r    <= {CHANNELS{IDLE_LEVEL}};
            any_change_r <= 1'b0;
        end else begin
            pin_out_r    <= pin_next_s;
            any_change_r <= |(rise_s | fall_s);
        end
    end

    assign pin_out    = pin_out_r;
    assign rise       = rise_s;
    assign fall       = fall_s;
    assign any_change = any_change_r;

endmodule

// File: tb/tb_pmod_input_conditioner.sv
// Directed self-checking bench for pmod_input_conditioner (8 channels, defaults).
module tb_pmod_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic [7:0] pin_in;
    logic [1:0] mode;
    logic [7:0] pin_out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       any_change;

    int checks;
    int fails;

    pmod_input_conditioner #(
        .CHANNELS(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .IDLE_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pin_in(pin_in), .mode(mode),
        .pin_out(pin_out), .rise(rise), .fall(fall), .any_change(any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for three edges with the given pins/mode, then releases;
    // the next posedge is edge 1 after release.
    task automatic reset_dut(input logic [7:0] pins, input logic [1:0] m);
        rst_n  = 1'b0;
        pin_in = pins;
        mode   = m;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut(8'hFF, 2'b01);
        rst_n = 1'b0;
        tick();
        checks++;
        if ({pin_out, rise, fall, any_change} !== 25'd0) begin
            fails++;
            $display("FAIL reset_vals pin_out=%h rise=%h fall=%h any=%b required all 0",
                     pin_out, rise, fall, any_change);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (rise !== ((k == 18) ? 8'hFF : 8'h00)) begin
                fails++;
                $display("FAIL reset_rise edge=%0d rise=%h required=%h", k, rise,
                         (k == 18) ? 8'hFF : 8'h00);
            end
            checks++;
            if (pin_out !== ((k >= 19) ? 8'hFF : 8'h00)) begin
                fails++;
                $display("FAIL reset_level edge=%0d pin_out=%h required=%h", k, pin_out,
                         (k >= 19) ? 8'hFF : 8'h00);
            end
        end
    endtask

    task automatic test_glitch();
        // 15-cycle pulse must be rejected
        reset_dut(8'h00, 2'b01);
        pin_in[0] = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 15) pin_in[0] = 1'b0;
            checks++;
            if ({rise, fall, pin_out, any_change} !== 25'd0) begin
                fails++;
                $display("FAIL glitch15 edge=%0d rise=%h fall=%h pin_out=%h any=%b required 0",
                         k, rise, fall, pin_out, any_change);
            end
        end
        // 16-cycle pulse is accepted
        reset_dut(8'h00, 2'b01);
        pin_in[0] = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 16) pin_in[0] = 1'b0;
            checks++;
            if (rise !== ((k == 18) ? 8'h01 : 8'h00)) begin
                fails++;
                $display("FAIL glitch16_rise edge=%0d rise=%h", k, rise);
            end
            checks++;
            if (any_change !== (k == 19)) begin
                fails++;
                $display("FAIL glitch16_any edge=%0d any=%b required=%b", k, any_change, k == 19);
            end
            checks++;
            if (pin_out[0] !== (k >= 19)) begin
                fails++;
                $display("FAIL glitch16_level edge=%0d pin_out0=%b required=%b", k, pin_out[0], k >= 19);
            end
        end
    endtask

    task automatic test_toggle();
        logic old_v;
        logic new_v;
        reset_dut(8'h00, 2'b10);
        for (int p = 0; p < 3; p++) begin
            old_v = (p % 2 == 1);
            new_v = (p % 2 == 0);
            pin_in[3] = 1'b1;
            for (int k = 1; k <= 80; k++) begin
                tick();
                if (k == 40) pin_in[3] = 1'b0;
                checks++;
                if (pin_out !== {4'h0, ((k >= 19) ? new_v : old_v), 3'b000}) begin
                    fails++;
                    $display("FAIL toggle press=%0d edge=%0d pin_out=%h required bit3=%b",
                             p, k, pin_out, (k >= 19) ? new_v : old_v);
                end
                checks++;
                if ({rise, fall} !== {((k == 18) ? 8'h08 : 8'h00), ((k == 58) ? 8'h08 : 8'h00)}) begin
                    fails++;
                    $display("FAIL toggle_edges press=%0d edge=%0d rise=%h fall=%h", p, k, rise, fall);
                end
            end
        end
    endtask

    task automatic test_pulse_raw();
        reset_dut(8'h00, 2'b11);
        pin_in[5] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 40) pin_in[5] = 1'b0;
            checks++;
            if (pin_out !== ((k == 19) ? 8'h20 : 8'h00)) begin
                fails++;
                $display("FAIL pulse edge=%0d pin_out=%h required=%h", k, pin_out,
                         (k == 19) ? 8'h20 : 8'h00);
            end
        end
        mode = 2'b00;
        pin_in[5] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) pin_in[5] = 1'b0;
            checks++;
            if (pin_out !== ((k >= 3 && k <= 5) ? 8'h20 : 8'h00)) begin
                fails++;
                $display("FAIL raw edge=%0d pin_out=%h required=%h", k, pin_out,
                         (k >= 3 && k <= 5) ? 8'h20 : 8'h00);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        reset_dut(8'h00, 2'b01);
        pin_in[1] = 1'b1;
        repeat (12) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({rise, pin_out} !== 16'h0000) begin
            fails++;
            $display("FAIL midreset_hold rise=%h pin_out=%h required 0", rise, pin_out);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (rise !== ((k == 18) ? 8'h02 : 8'h00)) begin
                fails++;
                $display("FAIL midreset_rise edge=%0d rise=%h required=%h", k, rise,
                         (k == 18) ? 8'h02 : 8'h00);
            end
        end
    endtask

    task automatic test_simultaneous();
        reset_dut(8'h04, 2'b01);
        repeat (25) tick();
        pin_in = 8'h81;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({rise, fall} !== ((k == 18) ? 16'h8104 : 16'h0000)) begin
                fails++;
                $display("FAIL simul edge=%0d rise=%h fall=%h required rise=81 fall=04 at 18",
                         k, rise, fall);
            end
            checks++;
            if (any_change !== (k == 19)) begin
                fails++;
                $display("FAIL simul_any edge=%0d any=%b required=%b", k, any_change, k == 19);
            end
        end
        checks++;
        if (pin_out !== 8'h81) begin
            fails++;
            $display("FAIL simul_level pin_out=%h required=81", pin_out);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        pin_in = 8'h00;
        mode   = 2'b01;
        test_reset();
        test_glitch();
        test_toggle();
        test_pulse_raw();
        test_reset_mid_debounce();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
